// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the memory-side blocks.
//   word_t      : 32-bit data/address word
//   ramstate_t  : RAM model handshake state (FREE/BUSY/ACCESS/ERROR)
//   arb_state_t : arbiter sequencer states (IDLE/GRANT)
//   owner_t     : arbiter owner record {cpu, is_data}
// Helper functions cover one-hot to index conversion and round-robin wrap.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   // Wide enough for up to 16 cores; the arbiter uses only the low bits.
   localparam int CPU_FIELD_W = 4;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [CPU_FIELD_W-1:0] cpu;
      logic                   is_data;
   } owner_t;

   // Index of the single set bit of a one-hot vector (0 when empty).
   function automatic logic [CPU_FIELD_W-1:0] onehot_to_idx(input logic [15:0] oh);
      logic [CPU_FIELD_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         idx = idx | ({CPU_FIELD_W{oh[i]}} & CPU_FIELD_W'(i));
      end
      return idx;
   endfunction

   // cpu + 1 modulo n.
   function automatic logic [CPU_FIELD_W-1:0] wrap_inc(input logic [CPU_FIELD_W-1:0] cpu,
                                                        input int unsigned           n);
      logic [CPU_FIELD_W-1:0] nxt;
      nxt = (cpu == CPU_FIELD_W'(n - 32'd1)) ? '0 : cpu + {{(CPU_FIELD_W-1){1'b0}}, 1'b1};
      return nxt;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin selector.
//   req   in  N   request vector
//   start in  PW  index with highest priority this cycle
//   grant out N   one-hot grant (first requester at or after start)
//   valid out 1   any request present
module rr_pick #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] start,
   output logic [N-1:0]  grant,
   output logic          valid
);

   logic          taken_s;
   logic [PW-1:0] idx_s;

   // Scan from start with wrap; the first requester found takes the grant.
   always_comb begin
      grant   = '0;
      taken_s = 1'b0;
      idx_s   = '0;
      for (int k = 0; k < N; k++) begin
         idx_s        = PW'((int'(start) + k) % N);
         grant[idx_s] = req[idx_s] & ~taken_s;
         taken_s      = taken_s | req[idx_s];
      end
   end

   assign valid = |req;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port among CPUS cores' icache and dcache.
//   CLK, RST            clock, asynchronous active-high reset
//   iREN/iaddr          per-core fetch request and address
//   dREN/dWEN/daddr/dstore  per-core data request, address, write data
//   iwait/dwait         per-core wait (0 only in the completion cycle)
//   iload/dload         per-core return data, valid when wait is 0, else 0
//   ramREN/ramWEN/ramaddr/ramstore  RAM request side
//   ramload/ramstate    RAM response side
//   grant_id            debug: current owner as {cpu, is_data}
// Data beats fetch; a fetch that has watched STARVE_LIMIT data completions
// while pending is promoted above data. Each class is round-robin from rr_ptr.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter  int CPUS         = 2,
   parameter  int STARVE_LIMIT = 4,
   localparam int GW           = $clog2(2 * CPUS)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [CPUS-1:0]       iREN,
   input  logic [CPUS-1:0][31:0] iaddr,
   input  logic [CPUS-1:0]       dREN,
   input  logic [CPUS-1:0]       dWEN,
   input  logic [CPUS-1:0][31:0] daddr,
   input  logic [CPUS-1:0][31:0] dstore,
   output logic [CPUS-1:0]       iwait,
   output logic [CPUS-1:0]       dwait,
   output logic [CPUS-1:0][31:0] iload,
   output logic [CPUS-1:0][31:0] dload,
   output logic                  ramREN,
   output logic                  ramWEN,
   output logic [31:0]           ramaddr,
   output logic [31:0]           ramstore,
   input  logic [31:0]           ramload,
   input  logic [1:0]            ramstate,
   output logic [GW-1:0]         grant_id
);

   localparam int CW = GW - 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   arb_state_t    state_r, state_n_s;
   owner_t        owner_r, owner_n_s;
   logic [CW-1:0] rr_ptr_r, rr_ptr_n_s;
   logic [SW-1:0] starve_cnt_r [CPUS];

   ramstate_t     ram_st_s;
   logic [CPUS-1:0] starved_req_s, data_req_s;
   logic [CPUS-1:0] starved_gnt_s, data_gnt_s, fetch_gnt_s;
   logic            starved_vld_s, data_vld_s, fetch_vld_s;
   logic [CPUS-1:0] owner_sel_s, active_s;
   logic            in_grant_s, live_s, done_s;

   assign ram_st_s   = ramstate_t'(ramstate);
   assign data_req_s = dREN | dWEN;
   assign in_grant_s = (state_r == GRANT);
   assign done_s     = in_grant_s & live_s & (ram_st_s == ACCESS);
   assign active_s   = owner_sel_s & {CPUS{in_grant_s}};
   assign grant_id   = {owner_r.cpu[CW-1:0], owner_r.is_data};

   // Promoted fetch requests: pending fetch whose counter reached the limit.
   always_comb begin
      starved_req_s = '0;
      for (int i = 0; i < CPUS; i++) begin
         starved_req_s[i] = iREN[i] & (starve_cnt_r[i] == SW'(STARVE_LIMIT));
      end
   end

   rr_pick #(.N(CPUS), .PW(CW)) u_pick_starved (
      .req(starved_req_s), .start(rr_ptr_r), .grant(starved_gnt_s), .valid(starved_vld_s));
   rr_pick #(.N(CPUS), .PW(CW)) u_pick_data (
      .req(data_req_s), .start(rr_ptr_r), .grant(data_gnt_s), .valid(data_vld_s));
   rr_pick #(.N(CPUS), .PW(CW)) u_pick_fetch (
      .req(iREN), .start(rr_ptr_r), .grant(fetch_gnt_s), .valid(fetch_vld_s));

   // Owner decode; live_s drops when the owner withdraws its request (abort).
   always_comb begin
      owner_sel_s = '0;
      live_s      = 1'b0;
      for (int i = 0; i < CPUS; i++) begin
         owner_sel_s[i] = (owner_r.cpu == CPU_FIELD_W'(i));
         live_s = live_s | (owner_sel_s[i] &
                            (owner_r.is_data ? data_req_s[i] : iREN[i]));
      end
   end

   // Next-state, next-owner and round-robin pointer.
   always_comb begin
      state_n_s  = state_r;
      owner_n_s  = owner_r;
      rr_ptr_n_s = rr_ptr_r;
      case (state_r)
         IDLE: begin
            if (starved_vld_s) begin
               state_n_s         = GRANT;
               owner_n_s.cpu     = onehot_to_idx(16'(starved_gnt_s));
               owner_n_s.is_data = 1'b0;
            end else if (data_vld_s) begin
               state_n_s         = GRANT;
               owner_n_s.cpu     = onehot_to_idx(16'(data_gnt_s));
               owner_n_s.is_data = 1'b1;
            end else if (fetch_vld_s) begin
               state_n_s         = GRANT;
               owner_n_s.cpu     = onehot_to_idx(16'(fetch_gnt_s));
               owner_n_s.is_data = 1'b0;
            end else begin
               state_n_s = IDLE;
            end
         end
         GRANT: begin
            if (!live_s) begin
               // Abort: pointer untouched so the same order is retried.
               state_n_s = IDLE;
            end else if (done_s) begin
               state_n_s  = IDLE;
               rr_ptr_n_s = CW'(wrap_inc(owner_r.cpu, CPUS));
            end else begin
               state_n_s = GRANT;
            end
         end
         default: begin
            state_n_s = IDLE;
         end
      endcase
   end

   // Sequencer, owner and round-robin pointer registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r  <= IDLE;
         owner_r  <= '0;
         rr_ptr_r <= '0;
      end else begin
         state_r  <= state_n_s;
         owner_r  <= owner_n_s;
         rr_ptr_r <= rr_ptr_n_s;
      end
   end

   // Per-core fetch starvation counters.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < CPUS; i++) begin
            starve_cnt_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CPUS; i++) begin
            if (!iREN[i]) begin
               starve_cnt_r[i] <= '0;
            end else if (done_s && !owner_r.is_data && owner_sel_s[i]) begin
               starve_cnt_r[i] <= '0;
            end else if (done_s && owner_r.is_data &&
                         (starve_cnt_r[i] != SW'(STARVE_LIMIT))) begin
               starve_cnt_r[i] <= starve_cnt_r[i] + SW'(1);
            end else begin
               starve_cnt_r[i] <= starve_cnt_r[i];
            end
         end
      end
   end

   // RAM drive and per-core wait/return data. Strobes follow the owner's live
   // inputs, so a write wins over a read and an abort drops them at once.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = '1;
      dwait    = '1;
      iload    = '0;
      dload    = '0;
      for (int i = 0; i < CPUS; i++) begin
         ramWEN   = ramWEN | (active_s[i] & owner_r.is_data & dWEN[i]);
         ramREN   = ramREN | (active_s[i] & (owner_r.is_data ? (dREN[i] & ~dWEN[i])
                                                             : iREN[i]));
         ramaddr  = ramaddr | ({32{active_s[i]}} &
                               (owner_r.is_data ? daddr[i] : iaddr[i]));
         ramstore = ramstore | ({32{active_s[i] & owner_r.is_data}} & dstore[i]);
         iwait[i] = ~(done_s & owner_sel_s[i] & ~owner_r.is_data);
         dwait[i] = ~(done_s & owner_sel_s[i] &  owner_r.is_data);
         iload[i] = {32{~iwait[i]}} & ramload;
         dload[i] = {32{~dwait[i]}} & ramload;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (CPUS=2, STARVE_LIMIT=4).
// Expected completions are queued as stimulus is driven and popped when a
// wait line drops. A small RAM model answers after a programmable latency.
module tb_mem_arbiter;

   localparam int CPUS = 2;

   typedef struct packed {
      logic        is_data;
      logic        cpu;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   logic              CLK;
   logic              RST;
   logic [1:0]        iREN, dREN, dWEN;
   logic [1:0][31:0]  iaddr, daddr, dstore;
   logic [1:0]        iwait, dwait;
   logic [1:0][31:0]  iload, dload;
   logic              ramREN, ramWEN;
   logic [31:0]       ramaddr, ramstore, ramload;
   logic [1:0]        ramstate;
   logic [1:0]        grant_id;

   exp_t  sb_q[$];
   int    err_cnt = 0;
   int    chk_cnt = 0;
   int    done_total = 0;
   int    acc_cnt = 0;
   int    lat = 0;
   logic  err_mode = 1'b0;
   logic  ld_ovr = 1'b0;
   logic [31:0] ld_val = 32'h0;
   logic  drop_on_done = 1'b1;
   logic [1:0] pend_i, pend_d;
   logic [1:0] iwait_smp, dwait_smp, gid_smp;
   logic       ren_smp, wen_smp;

   mem_arbiter #(.CPUS(2), .STARVE_LIMIT(4)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .grant_id(grant_id)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] ram_f(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // RAM model: counts cycles of a held strobe, answers ACCESS after lat.
   always @(posedge CLK) begin
      if (ramREN | ramWEN) acc_cnt <= acc_cnt + 1;
      else                 acc_cnt <= 0;
   end

   always_comb begin
      if (!(ramREN | ramWEN))  ramstate = 2'd0;
      else if (err_mode)       ramstate = 2'd3;
      else if (acc_cnt >= lat) ramstate = 2'd2;
      else                     ramstate = 2'd1;
      ramload = ld_ovr ? ld_val : ram_f(ramaddr);
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push(input logic is_data, input logic cpu,
                       input logic [31:0] addr, input logic [31:0] data);
      exp_t e;
      e.is_data = is_data; e.cpu = cpu; e.addr = addr; e.data = data;
      sb_q.push_back(e);
   endtask

   task automatic compl(input logic is_data, input logic cpu,
                        input logic [31:0] addr, input logic [31:0] data);
      exp_t e;
      done_total++;
      if (sb_q.size() == 0) begin
         check("unexpected_done", {is_data, cpu}, 64'hFF);
      end else begin
         e = sb_q.pop_front();
         check("grant_id", gid_smp, {e.cpu, e.is_data});
         check("kind_cpu", {is_data, cpu}, {e.is_data, e.cpu});
         check("addr_data", {addr, data}, {e.addr, e.data});
      end
   endtask

   // One clock: sample at negedge, score completions, then drive after posedge.
   task automatic step();
      @(negedge CLK);
      iwait_smp = iwait; dwait_smp = dwait; gid_smp = grant_id;
      ren_smp = ramREN; wen_smp = ramWEN;
      for (int i = 0; i < CPUS; i++) begin
         if (!iwait[i]) begin
            compl(1'b0, i[0], ramaddr, iload[i]);
            pend_i[i] = 1'b1;
         end
         if (!dwait[i]) begin
            compl(1'b1, i[0], ramaddr, dWEN[i] ? ramstore : dload[i]);
            pend_d[i] = 1'b1;
         end
      end
      @(posedge CLK); #1;
      if (drop_on_done) begin
         for (int i = 0; i < CPUS; i++) begin
            if (pend_i[i]) iREN[i] = 1'b0;
            if (pend_d[i]) begin dREN[i] = 1'b0; dWEN[i] = 1'b0; end
         end
      end
      pend_i = '0; pend_d = '0;
   endtask

   task automatic run_until(input int target);
      int budget;
      budget = 300;
      while (done_total < target && budget > 0) begin
         step();
         budget--;
      end
      check("done_count", 64'(done_total), 64'(target));
   endtask

   task automatic apply_reset();
      RST = 1'b1;
      iREN = '0; dREN = '0; dWEN = '0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   initial begin
      int low_n, low_at, base;
      RST = 1'b1;
      iREN = '0; dREN = '0; dWEN = '0;
      iaddr = '0; daddr = '0; dstore = '0;
      pend_i = '0; pend_d = '0;

      // Reset state
      @(negedge CLK);
      check("rst_iwait", iwait, 2'b11);
      check("rst_dwait", dwait, 2'b11);
      check("rst_strobes", {ramREN, ramWEN}, 2'b00);
      check("rst_addr_store", {ramaddr, ramstore}, 64'h0);
      check("rst_grant_id", grant_id, 2'b00);
      check("rst_loads", {iload, dload}, 64'h0);
      @(posedge CLK); #1 RST = 1'b0;

      // Single fetch, two BUSY cycles then ACCESS
      lat = 2; ld_ovr = 1'b1; ld_val = 32'hDEAD_BEEF;
      iREN[0] = 1'b1; iaddr[0] = 32'h40;
      push(1'b0, 1'b0, 32'h40, 32'hDEAD_BEEF);
      low_n = 0; low_at = 0;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         step();
         if (!iwait_smp[0]) begin low_n++; low_at = cyc; end
         if (cyc == 5) check("fetch_ren_drop", ren_smp, 1'b0);
      end
      check("fetch_low_count", 64'(low_n), 64'd1);
      check("fetch_low_cycle", 64'(low_at), 64'd4);
      ld_ovr = 1'b0;

      // Data beats fetch on the same core
      lat = 0; base = done_total;
      iREN[0] = 1'b1; iaddr[0] = 32'h44;
      dREN[0] = 1'b1; daddr[0] = 32'h80;
      push(1'b1, 1'b0, 32'h80, ram_f(32'h80));
      push(1'b0, 1'b0, 32'h44, ram_f(32'h44));
      run_until(base + 2);

      // Round-robin between two held writers
      apply_reset();
      lat = 1; drop_on_done = 1'b0; base = done_total;
      dWEN = 2'b11;
      daddr[0] = 32'h100; dstore[0] = 32'h1111_0000;
      daddr[1] = 32'h200; dstore[1] = 32'h2222_0000;
      for (int k = 0; k < 2; k++) begin
         push(1'b1, 1'b0, 32'h100, 32'h1111_0000);
         push(1'b1, 1'b1, 32'h200, 32'h2222_0000);
      end
      run_until(base + 4);
      dWEN = 2'b00;

      // Starvation: four data completions, then the promoted fetch
      lat = 0; base = done_total;
      dREN[1] = 1'b1; daddr[1] = 32'h300;
      iREN[0] = 1'b1; iaddr[0] = 32'h500;
      for (int k = 0; k < 4; k++) push(1'b1, 1'b1, 32'h300, ram_f(32'h300));
      push(1'b0, 1'b0, 32'h500, ram_f(32'h500));
      run_until(base + 5);
      check("starve_clear", 64'(dut.starve_cnt_r[0]), 64'd0);
      dREN[1] = 1'b0; iREN[0] = 1'b0;
      drop_on_done = 1'b1;

      // ERROR hold then abort; pointer must still favour core1
      err_mode = 1'b1; base = done_total;
      dREN[1] = 1'b1; daddr[1] = 32'h600;
      step();
      for (int k = 0; k < 3; k++) begin
         step();
         check("err_hold_ren", ren_smp, 1'b1);
         check("err_hold_dwait", dwait_smp, 2'b11);
      end
      dREN[1] = 1'b0;
      step();
      check("abort_ren", ren_smp, 1'b0);
      check("abort_dwait", dwait_smp, 2'b11);
      err_mode = 1'b0;
      dREN = 2'b11; daddr[0] = 32'h700;
      push(1'b1, 1'b1, 32'h600, ram_f(32'h600));
      push(1'b1, 1'b0, 32'h700, ram_f(32'h700));
      run_until(base + 2);

      // Reset in the middle of a write grant
      lat = 5; base = done_total;
      dWEN[0] = 1'b1; daddr[0] = 32'h900; dstore[0] = 32'h9999_0000;
      step();
      step();
      check("pre_rst_wen", wen_smp, 1'b1);
      check("pre_rst_gid", gid_smp, 2'b01);
      #2 RST = 1'b1;
      #1;
      check("mid_rst_wen", ramWEN, 1'b0);
      check("mid_rst_waits", {iwait, dwait}, 4'b1111);
      check("mid_rst_gid", grant_id, 2'b00);
      @(posedge CLK); #1 RST = 1'b0;
      lat = 1;
      push(1'b1, 1'b0, 32'h900, 32'h9999_0000);
      run_until(base + 1);

      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
